// File: rtl/seg7_scan_ctrl.sv
// 8-digit common-anode 7-segment scan controller, one hex nibble per digit.
// Optional leading-zero blanking: define SEG_LZB_EN.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV = 30000,
  parameter int CNT_W    = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wen,
  input  logic [31:0] wdata,
  input  logic        blank,
  output logic [7:0]  led_en,
  output logic [7:0]  led_seg,
  output logic        active
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] TC = CNT_W'(SCAN_DIV - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_data;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_en;
  logic [7:0]       r_seg;
  logic             r_act;

  logic             w_tc;
  logic [3:0]       w_nib;
  logic [7:0]       w_dec;
  logic             w_lzb;
  logic [7:0]       w_en_d;
  logic [7:0]       w_seg_d;
  logic             w_act_d;

  assign w_tc  = (r_cnt == TC);
  assign w_nib = r_data[{r_idx, 2'b00} +: 4];

`ifdef SEG_LZB_EN
  logic [31:0] w_hi;
  // Everything from the current digit upward is zero: suppress it.
  assign w_hi  = r_data >> {r_idx, 2'b00};
  assign w_lzb = (r_idx != 3'd0) && (w_hi == 32'd0);
`else
  assign w_lzb = 1'b0;
`endif

  always_comb begin
    w_dec = 8'hFF;
    unique case (w_nib)
      4'h0: w_dec = 8'hC0;
      4'h1: w_dec = 8'hF9;
      4'h2: w_dec = 8'hA4;
      4'h3: w_dec = 8'hB0;
      4'h4: w_dec = 8'h99;
      4'h5: w_dec = 8'h92;
      4'h6: w_dec = 8'h82;
      4'h7: w_dec = 8'hF8;
      4'h8: w_dec = 8'h80;
      4'h9: w_dec = 8'h90;
      4'hA: w_dec = 8'h88;
      4'hB: w_dec = 8'h83;
      4'hC: w_dec = 8'hC6;
      4'hD: w_dec = 8'hA1;
      4'hE: w_dec = 8'h86;
      4'hF: w_dec = 8'h8E;
      default: w_dec = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (wen) w_state_nxt = SCAN;
      SCAN:    w_state_nxt = SCAN;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_en_d  = 8'hFF;
    w_seg_d = 8'hFF;
    w_act_d = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_act_d = wen;
      end
      SCAN: begin
        w_act_d = 1'b1;
        if (!blank && !w_lzb) begin
          w_en_d  = ~(8'h01 << r_idx);
          w_seg_d = w_dec;
        end
      end
      default: begin
        w_act_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_idx  <= '0;
      r_en   <= 8'hFF;
      r_seg  <= 8'hFF;
      r_act  <= 1'b0;
    end else begin
      r_en  <= w_en_d;
      r_seg <= w_seg_d;
      r_act <= w_act_d;
      unique case (r_state)
        IDLE: begin
          if (wen) begin
            r_data <= wdata;
            r_cnt  <= '0;
            r_idx  <= '0;
          end
        end
        SCAN: begin
          // A write only swaps the data; dwell timing is untouched.
          if (wen) r_data <= wdata;
          if (w_tc) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign led_en  = r_en;
  assign led_seg = r_seg;
  assign active  = r_act;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: elapsed-time display model, directed + random.
// Build with SEG_LZB_EN to check leading-zero blanking.
module tb_seg7_scan_ctrl;

  localparam int DIV = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        wen   = 1'b0;
  logic        blank = 1'b0;
  logic [31:0] wdata = '0;
  logic [7:0]  led_en;
  logic [7:0]  led_seg;
  logic        active;

  int vectors     = 0;
  int miscompares = 0;

  seg7_scan_ctrl #(
    .SCAN_DIV(DIV),
    .CNT_W   (25)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wen    (wen),
    .wdata  (wdata),
    .blank  (blank),
    .led_en (led_en),
    .led_seg(led_seg),
    .active (active)
  );

  always #5 clk = ~clk;

  logic [7:0] seg_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Model: digit on screen is a pure function of edges elapsed since start.
  bit          m_scan;
  logic [31:0] m_data;
  int unsigned m_k;
  logic [7:0]  m_en;
  logic [7:0]  m_seg;
  logic        m_act;
  int unsigned m_d;
  bit          m_lz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_scan = 1'b0;
      m_data = '0;
      m_k    = 0;
      m_en   = 8'hFF;
      m_seg  = 8'hFF;
      m_act  = 1'b0;
    end else if (!m_scan) begin
      if (wen) begin
        m_scan = 1'b1;
        m_data = wdata;
        m_k    = 0;
        m_act  = 1'b1;
      end
    end else begin
      m_d  = (m_k / DIV) % 8;
      m_lz = 1'b0;
`ifdef SEG_LZB_EN
      m_lz = (m_d != 0) && ((m_data >> (4 * m_d)) == 32'd0);
`endif
      if (blank || m_lz) begin
        m_en  = 8'hFF;
        m_seg = 8'hFF;
      end else begin
        m_en  = ~(8'h01 << m_d);
        m_seg = seg_tab[m_data[4*m_d +: 4]];
      end
      m_k = m_k + 1;
      if (wen) m_data = wdata;
    end
  end

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic lit(input string nm, input logic [7:0] en,
                     input logic [7:0] seg, input logic act);
    chk({nm, ".en"}, led_en, en);
    chk({nm, ".seg"}, led_seg, seg);
    chk({nm, ".act"}, {7'd0, active}, {7'd0, act});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    chk("model.en", led_en, m_en);
    chk("model.seg", led_seg, m_seg);
    chk("model.act", {7'd0, active}, {7'd0, m_act});
  end

  logic [7:0] en_lit  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                              8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] seg_lit [8] = '{8'h80, 8'hF8, 8'h82, 8'h92,
                              8'h99, 8'hB0, 8'hA4, 8'hF9};

  initial begin
    step(3);
    lit("reset", 8'hFF, 8'hFF, 1'b0);
    rst_n = 1'b1;
    step(100);
    lit("idle100", 8'hFF, 8'hFF, 1'b0);

    wdata = 32'h12345678;
    wen   = 1'b1;
    step(1);
    wen   = 1'b0;
    step(1);
    for (int k = 0; k < 8; k++) begin
      lit($sformatf("scan%0d", k), en_lit[k], seg_lit[k], 1'b1);
      step(DIV);
    end
    lit("wrap", 8'hFE, 8'h80, 1'b1);

    step(11);
    wdata = 32'hDEADBEEF;
    wen   = 1'b1;
    step(1);
    wen   = 1'b0;
    step(1);
    lit("rewr", 8'hF7, 8'h83, 1'b1);
    step(2);
    lit("rewr_end", 8'hF7, 8'h83, 1'b1);
    step(1);
    lit("rewr_nxt", 8'hEF, 8'hA1, 1'b1);

    blank = 1'b1;
    step(1);
    lit("blank1", 8'hFF, 8'hFF, 1'b1);
    step(5);
    lit("blank6", 8'hFF, 8'hFF, 1'b1);
    blank = 1'b0;
    step(1);
    lit("unblank", 8'hDF, 8'h88, 1'b1);

    step(3);
    #2 rst_n = 1'b0;
    #1 lit("async_rst", 8'hFF, 8'hFF, 1'b0);
    #1 rst_n = 1'b1;
    step(20);
    lit("post_rst", 8'hFF, 8'hFF, 1'b0);

    wdata = 32'h00000A05;
    wen   = 1'b1;
    step(1);
    wen   = 1'b0;
    step(1);
    lit("lz0", 8'hFE, 8'h92, 1'b1);
    step(DIV);
    lit("lz1", 8'hFD, 8'hC0, 1'b1);
    step(DIV);
    lit("lz2", 8'hFB, 8'h88, 1'b1);
    step(DIV);
`ifdef SEG_LZB_EN
    lit("lz3", 8'hFF, 8'hFF, 1'b1);
`else
    lit("lz3", 8'hF7, 8'hC0, 1'b1);
`endif

    for (int i = 0; i < 3000; i++) begin
      wen   = ($urandom_range(0, 15) == 0);
      wdata = $urandom >> ($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 9) == 0) blank = ~blank;
      if (i == 1500 || i == 2200) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
